// File: rtl/param_fifo.sv
// First-word-fall-through FIFO: read_data/status come straight from registered pointers, zero read latency.
// Writes into a full FIFO are accepted only alongside a read; rejected requests raise sticky error flags.
module param_fifo #(
   parameter int WIDTH              = 32,
   parameter int DEPTH              = 16,
   parameter int ALMOST_FULL_THRESH = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       write_en,
   input  logic [WIDTH-1:0]           write_data,
   input  logic                       read_en,
   output logic [WIDTH-1:0]           read_data,
   output logic                       queue_full,
   output logic                       queue_empty,
   output logic                       almost_full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow_err,
   output logic                       underflow_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] AF_THRESH = PW'(ALMOST_FULL_THRESH);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic             wr_acc;
   logic             rd_acc;

   // Pointer MSB is the wrap bit: equal index with differing wrap bits means full.
   assign count       = tail - head;
   assign queue_empty = (head == tail);
   assign queue_full  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
   assign almost_full = (count >= AF_THRESH);
   assign read_data   = queue_empty ? '0 : mem[head[AW-1:0]];

   assign wr_acc = write_en && (!queue_full || read_en);
   assign rd_acc = read_en && !queue_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         head          <= '0;
         tail          <= '0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         if (flush) begin
            head <= '0;
            tail <= '0;
         end else begin
            if (wr_acc) tail <= tail + PTR_ONE;
            if (rd_acc) head <= head + PTR_ONE;
            if (write_en && queue_full && !read_en) overflow_err <= 1'b1;
            if (read_en && queue_empty)             underflow_err <= 1'b1;
         end
      end
   end

   // Storage carries no reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (!rst && !flush && wr_acc) mem[tail[AW-1:0]] <= write_data;
   end

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo (DEPTH=4): directed scenarios plus random traffic against a queue-based model.
module tb_param_fifo;
   localparam int W  = 32;
   localparam int D  = 4;
   localparam int TH = 3;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst, flush, write_en, read_en;
   logic [W-1:0]  write_data, read_data;
   logic          queue_full, queue_empty, almost_full, overflow_err, underflow_err;
   logic [CW-1:0] count;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] mq[$];
   logic         m_ovf = 1'b0;
   logic         m_unf = 1'b0;

   always #5 clk = ~clk;

   param_fifo #(.WIDTH(W), .DEPTH(D), .ALMOST_FULL_THRESH(TH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .write_en(write_en), .write_data(write_data), .read_en(read_en),
      .read_data(read_data), .queue_full(queue_full), .queue_empty(queue_empty),
      .almost_full(almost_full), .count(count),
      .overflow_err(overflow_err), .underflow_err(underflow_err)
   );

   // Drive one cycle of inputs, advance the model by the FIFO rules, sample #1 after the edge.
   task automatic cycle(input logic we, input logic [W-1:0] wd, input logic re,
                        input logic fl, input logic rs);
      bit full, empty;
      full  = (mq.size() == D);
      empty = (mq.size() == 0);
      write_en = we; write_data = wd; read_en = re; flush = fl; rst = rs;
      @(posedge clk);
      if (rs) begin
         mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      end else if (fl) begin
         mq.delete();
      end else begin
         if (we && full && !re) m_ovf = 1'b1;
         if (re && empty)       m_unf = 1'b1;
         if (re && !empty)      void'(mq.pop_front());
         if (we && (!full || re)) mq.push_back(wd);
      end
      #1;
      write_en = 1'b0; read_en = 1'b0; flush = 1'b0; rst = 1'b0;
   endtask

   task automatic test_reset();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      checks++; if (queue_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b want=1", queue_empty); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
      checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", read_data); end
      checks++; if (queue_full !== 1'b0 || almost_full !== 1'b0) begin failures++; $display("FAIL reset_full_af got=%b%b want=00", queue_full, almost_full); end
      checks++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin failures++; $display("FAIL reset_errs got=%b%b want=00", overflow_err, underflow_err); end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < D; i++) begin
         cycle(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
         checks++; if (count !== CW'(i + 1)) begin failures++; $display("FAIL fill_count%0d got=%0d want=%0d", i, count, i + 1); end
         checks++; if (almost_full !== (i + 1 >= TH)) begin failures++; $display("FAIL fill_af%0d got=%b want=%b", i, almost_full, (i + 1 >= TH)); end
         checks++; if (queue_full !== (i == D - 1)) begin failures++; $display("FAIL fill_full%0d got=%b want=%b", i, queue_full, (i == D - 1)); end
      end
      cycle(1'b1, 32'hA4, 1'b0, 1'b0, 1'b0);
      checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL overflow_flag got=%b want=1", overflow_err); end
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL overflow_count got=%0d want=4", count); end
   endtask

   task automatic test_drain_underflow();
      for (int i = 0; i < D; i++) begin
         checks++; if (read_data !== 32'hA0 + 32'(i)) begin failures++; $display("FAIL drain_data%0d got=%h want=%h", i, read_data, 32'hA0 + 32'(i)); end
         cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
      checks++; if (queue_empty !== 1'b1 || read_data !== 32'h0) begin failures++; $display("FAIL drain_empty got=%b/%h want=1/0", queue_empty, read_data); end
      checks++; if (underflow_err !== 1'b0) begin failures++; $display("FAIL drain_unf_early got=%b want=0", underflow_err); end
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++; if (underflow_err !== 1'b1) begin failures++; $display("FAIL underflow_flag got=%b want=1", underflow_err); end
   endtask

   task automatic test_full_rw();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < D; i++) cycle(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0, 1'b0);
      checks++; if (read_data !== 32'hB0) begin failures++; $display("FAIL fullrw_head got=%h want=b0", read_data); end
      cycle(1'b1, 32'hB4, 1'b1, 1'b0, 1'b0);
      checks++; if (count !== 3'd4 || queue_full !== 1'b1) begin failures++; $display("FAIL fullrw_state got=%0d/%b want=4/1", count, queue_full); end
      checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL fullrw_ovf got=%b want=0", overflow_err); end
      for (int i = 1; i <= D; i++) begin
         checks++; if (read_data !== 32'hB0 + 32'(i)) begin failures++; $display("FAIL fullrw_data%0d got=%h want=%h", i, read_data, 32'hB0 + 32'(i)); end
         cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
   endtask

   task automatic test_wrap();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
         checks++; if (read_data !== 32'(i) || count !== 3'd1) begin failures++; $display("FAIL wrap_data%0d got=%h/%0d want=%h/1", i, read_data, count, 32'(i)); end
         cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
         checks++; if (count !== 3'd0) begin failures++; $display("FAIL wrap_count%0d got=%0d want=0", i, count); end
      end
      checks++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin failures++; $display("FAIL wrap_errs got=%b%b want=00", overflow_err, underflow_err); end
   endtask

   task automatic test_flush_reset();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0);
      checks++; if (count !== 3'd0 || queue_empty !== 1'b1 || read_data !== 32'h0) begin failures++; $display("FAIL flush_state got=%0d/%b/%h want=0/1/0", count, queue_empty, read_data); end
      cycle(1'b1, 32'hC0, 1'b0, 1'b0, 1'b0);
      checks++; if (read_data !== 32'hC0 || count !== 3'd1) begin failures++; $display("FAIL flush_after got=%h/%0d want=c0/1", read_data, count); end
      cycle(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'hC2, 1'b1, 1'b0, 1'b1);
      checks++; if (queue_empty !== 1'b1 || count !== 3'd0 || read_data !== 32'h0) begin failures++; $display("FAIL midreset_state got=%b/%0d/%h want=1/0/0", queue_empty, count, read_data); end
      checks++; if (queue_full !== 1'b0 || almost_full !== 1'b0 || overflow_err !== 1'b0 || underflow_err !== 1'b0) begin failures++; $display("FAIL midreset_flags got=%b%b%b%b want=0000", queue_full, almost_full, overflow_err, underflow_err); end
   endtask

   task automatic test_random();
      logic [W-1:0] exp_rd;
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int n = 0; n < 800; n++) begin
         cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 199) == 0));
         exp_rd = (mq.size() != 0) ? mq[0] : '0;
         checks++; if (count !== CW'(mq.size())) begin failures++; $display("FAIL rand_count n=%0d got=%0d want=%0d", n, count, mq.size()); end
         checks++; if (read_data !== exp_rd) begin failures++; $display("FAIL rand_rdata n=%0d got=%h want=%h", n, read_data, exp_rd); end
         checks++; if (queue_empty !== (mq.size() == 0) || queue_full !== (mq.size() == D) || almost_full !== (mq.size() >= TH)) begin
            failures++; $display("FAIL rand_status n=%0d got=%b%b%b want=%b%b%b", n, queue_empty, queue_full, almost_full, mq.size() == 0, mq.size() == D, mq.size() >= TH);
         end
         checks++; if (overflow_err !== m_ovf || underflow_err !== m_unf) begin failures++; $display("FAIL rand_errs n=%0d got=%b%b want=%b%b", n, overflow_err, underflow_err, m_ovf, m_unf); end
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; write_en = 1'b0; read_en = 1'b0; write_data = '0;
      test_reset();
      test_fill_overflow();
      test_drain_underflow();
      test_full_rw();
      test_wrap();
      test_flush_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
